// File: rtl/mips8_pkg.sv
// Shared definitions for the mips8 decode stage: instruction field layout,
// opcode constants, decode-controller state encoding and the decode register.
package mips8_pkg;

  localparam int FLUSH_DEPTH_DEF = 2;

  localparam int INS_W  = 20;
  localparam int OPC_HI = 19;
  localparam int OPC_LO = 15;
  localparam int RD_HI  = 14;
  localparam int RD_LO  = 12;
  localparam int RS1_HI = 11;
  localparam int RS1_LO = 9;
  localparam int RS2_HI = 8;
  localparam int RS2_LO = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef logic [4:0] opc_t;
  typedef logic [2:0] reg_t;

  localparam opc_t OP_NOP  = 5'b00000;
  localparam opc_t OP_LD   = 5'b10000;
  localparam opc_t OP_ST   = 5'b10001;
  localparam opc_t OP_JMP  = 5'b11000;
  localparam opc_t OP_BEQZ = 5'b11001;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    opc_t       opcode;
    reg_t       rd;
    reg_t       rs1;
    reg_t       rs2;
    logic [7:0] imm;
    logic [7:0] pc;
  } dec_t;

  function automatic logic is_alu(input opc_t op);
    return (op != OP_NOP) && (op != OP_LD) && (op != OP_ST) &&
           (op != OP_JMP) && (op != OP_BEQZ);
  endfunction

  function automatic logic reads_rs1(input opc_t op);
    return is_alu(op) || (op == OP_LD) || (op == OP_ST) || (op == OP_BEQZ);
  endfunction

  function automatic logic reads_rs2(input opc_t op);
    return is_alu(op) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: the instruction in decode is a valid LD whose destination
// is a source register of the instruction arriving from fetch.
module hazard_detect
  import mips8_pkg::*;
(
  input  logic valid_i,
  input  opc_t opcode_i,
  input  reg_t rd_i,
  input  opc_t in_opcode_i,
  input  reg_t in_rs1_i,
  input  reg_t in_rs2_i,
  output logic hazard_o
);

  logic ld_in_decode;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    ld_in_decode = valid_i && (opcode_i == OP_LD);
    rs1_hit      = reads_rs1(in_opcode_i) && (in_rs1_i == rd_i);
    rs2_hit      = reads_rs2(in_opcode_i) && (in_rs2_i == rd_i);
    hazard_o     = ld_in_decode && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/ins_decode_ctrl_block.sv
// Decode register plus the RUN/STALL/FLUSH controller that inserts load-use
// bubbles and squashes wrong-path instructions after a taken redirect.
module ins_decode_ctrl_block
  import mips8_pkg::*;
#(
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins,
  input  logic [7:0]  current_address,
  input  logic        zero_flag,
  output logic [7:0]  jmp_loc,
  output logic        pc_mux_sel,
  output logic        stall,
  output logic        stall_pm,
  output logic [4:0]  opcode_d,
  output logic [2:0]  rd_d,
  output logic [2:0]  rs1_d,
  output logic [2:0]  rs2_d,
  output logic [7:0]  imm_d,
  output logic [7:0]  pc_d,
  output logic        valid_d
);

  localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dec_t             dec_q, dec_d;
  dec_t             ins_fields;
  logic             hazard_raw;
  logic             hazard;
  logic             redirect;
  logic             squash;

  hazard_detect u_hazard (
    .valid_i     (dec_q.valid),
    .opcode_i    (dec_q.opcode),
    .rd_i        (dec_q.rd),
    .in_opcode_i (ins[OPC_HI:OPC_LO]),
    .in_rs1_i    (ins[RS1_HI:RS1_LO]),
    .in_rs2_i    (ins[RS2_HI:RS2_LO]),
    .hazard_o    (hazard_raw)
  );

  // Hazards and redirects are only acted on in RUN; STALL and FLUSH hold bubbles.
  always_comb begin
    redirect = (state_q == ST_RUN) && dec_q.valid &&
               ((dec_q.opcode == OP_JMP) ||
                ((dec_q.opcode == OP_BEQZ) && zero_flag));
    hazard   = (state_q == ST_RUN) && hazard_raw && !redirect;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
    end
  end

  // The redirect edge squashes the first wrong-path instruction; FLUSH squashes
  // the rest and its final cycle (counter at 0) decodes normally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    squash  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
          squash  = 1'b1;
        end else if (hazard) begin
          state_d = ST_STALL;
          squash  = 1'b1;
        end
      end
      ST_STALL: state_d = ST_RUN;
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          squash = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    ins_fields.valid  = (ins[OPC_HI:OPC_LO] != OP_NOP);
    ins_fields.opcode = ins[OPC_HI:OPC_LO];
    ins_fields.rd     = ins[RD_HI:RD_LO];
    ins_fields.rs1    = ins[RS1_HI:RS1_LO];
    ins_fields.rs2    = ins[RS2_HI:RS2_LO];
    ins_fields.imm    = ins[IMM_HI:IMM_LO];
    ins_fields.pc     = current_address;
    dec_d = squash ? '0 : ins_fields;
  end

  always_comb begin
    stall      = !reset && hazard;
    stall_pm   = !reset && hazard;
    pc_mux_sel = !reset && redirect;
    jmp_loc    = pc_mux_sel ? dec_q.imm : 8'h00;
  end

  assign opcode_d = dec_q.opcode;
  assign rd_d     = dec_q.rd;
  assign rs1_d    = dec_q.rs1;
  assign rs2_d    = dec_q.rs2;
  assign imm_d    = dec_q.imm;
  assign pc_d     = dec_q.pc;
  assign valid_d  = dec_q.valid;

endmodule

// File: tb/tb_ins_decode_ctrl_block.sv
// Vector-table bench for the decode controller: each row drives one cycle and
// carries the expected control outputs and whether ins reaches the decode register.
module tb_ins_decode_ctrl_block;

  localparam logic [4:0] NOP = 5'b00000, LD = 5'b10000, ST = 5'b10001;
  localparam logic [4:0] JMP = 5'b11000, BEQZ = 5'b11001, ALU = 5'b00010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] ins = '0;
  logic [7:0]  current_address = '0;
  logic        zero_flag = 1'b0;
  logic [7:0]  jmp_loc;
  logic        pc_mux_sel, stall, stall_pm, valid_d;
  logic [4:0]  opcode_d;
  logic [2:0]  rd_d, rs1_d, rs2_d;
  logic [7:0]  imm_d, pc_d;

  ins_decode_ctrl_block #(.FLUSH_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
    .zero_flag(zero_flag), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
    .stall(stall), .stall_pm(stall_pm), .opcode_d(opcode_d), .rd_d(rd_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .imm_d(imm_d), .pc_d(pc_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [19:0] ins;
    logic [7:0]  pc;
    logic        zf;
    logic        e_stall;
    logic        e_pmux;
    logic [7:0]  e_jmp;
    logic        e_load;
  } vec_t;

  vec_t        tbl[$];
  logic [30:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [19:0] rr(logic [4:0] op, logic [2:0] rd, logic [2:0] s1, logic [2:0] s2);
    return {op, rd, s1, s2, 6'b0};
  endfunction

  function automatic logic [19:0] ri(logic [4:0] op, logic [2:0] rd, logic [2:0] s1, logic [7:0] imm);
    return {op, rd, s1, 1'b0, imm};
  endfunction

  function automatic vec_t mkv(logic rst, logic [19:0] i, logic [7:0] pc, logic zf,
                               logic st, logic pm, logic [7:0] jl, logic ld);
    vec_t v;
    v.rst = rst; v.ins = i; v.pc = pc; v.zf = zf;
    v.e_stall = st; v.e_pmux = pm; v.e_jmp = jl; v.e_load = ld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    logic [30:0] e;
    logic [30:0] a;
    @(negedge clk);
    reset = v.rst; ins = v.ins; current_address = v.pc; zero_flag = v.zf;
    #1;
    chk("stall", {31'b0, stall}, {31'b0, v.e_stall});
    chk("stall_pm", {31'b0, stall_pm}, {31'b0, v.e_stall});
    chk("pc_mux_sel", {31'b0, pc_mux_sel}, {31'b0, v.e_pmux});
    chk("jmp_loc", {24'b0, jmp_loc}, {24'b0, v.e_jmp});
    if (v.e_load)
      exp_q.push_back({(v.ins[19:15] != NOP), v.ins[19:15], v.ins[14:12],
                       v.ins[11:9], v.ins[8:6], v.ins[7:0], v.pc});
    else
      exp_q.push_back('0);
    @(posedge clk);
    #1;
    a = {valid_d, opcode_d, rd_d, rs1_d, rs2_d, imm_d, pc_d};
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("decode_reg", {1'b0, a}, {1'b0, e});
    end
  endtask

  initial begin
    tbl.push_back(mkv(1, rr(ALU,1,2,3), 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mkv(0, 20'h0,         8'h01, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(LD,3,1,8'h05), 8'h02, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, rr(ALU,5,3,0), 8'h03, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mkv(0, rr(ALU,5,3,0), 8'h03, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(LD,3,1,8'h00), 8'h04, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, rr(ALU,6,2,4), 8'h05, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(LD,4,0,8'h00), 8'h06, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, rr(ST,0,1,4),  8'h07, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mkv(0, rr(ST,0,1,4),  8'h07, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(JMP,0,0,8'h40), 8'h08, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, rr(ALU,1,1,1), 8'h09, 0, 0, 1, 8'h40, 0));
    tbl.push_back(mkv(0, rr(ALU,1,1,1), 8'h0A, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mkv(0, rr(ALU,2,0,0), 8'h40, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(BEQZ,0,2,8'h10), 8'h41, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, 20'h0,         8'h42, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(BEQZ,0,2,8'h10), 8'h43, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, rr(ALU,1,1,1), 8'h44, 1, 0, 1, 8'h10, 0));
    tbl.push_back(mkv(0, rr(ALU,1,1,1), 8'h45, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mkv(0, rr(ALU,2,3,4), 8'h10, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(JMP,0,0,8'h22), 8'h11, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, rr(ALU,1,7,7), 8'h12, 0, 0, 1, 8'h22, 0));
    tbl.push_back(mkv(1, rr(ALU,1,7,7), 8'h13, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mkv(0, rr(ALU,3,1,2), 8'h50, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(LD,1,0,8'h00), 8'h51, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, ri(BEQZ,0,1,8'h08), 8'h52, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mkv(0, ri(BEQZ,0,1,8'h08), 8'h52, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mkv(0, rr(ALU,2,2,2), 8'h53, 1, 0, 1, 8'h08, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Flush drains, a JMP reaches decode, and reset lands in its redirect cycle.
    step(mkv(0, rr(ALU,1,1,1), 8'h54, 0, 0, 0, 8'h00, 0));
    step(mkv(0, rr(ALU,4,4,4), 8'h08, 0, 0, 0, 8'h00, 1));
    step(mkv(0, ri(JMP,0,0,8'h33), 8'h09, 0, 0, 0, 8'h00, 1));
    step(mkv(1, rr(ALU,1,1,1), 8'h0A, 0, 0, 0, 8'h00, 0));
    step(mkv(0, rr(ALU,5,1,1), 8'h60, 0, 0, 0, 8'h00, 1));
    // Load-use through rs2 of an ALU instruction.
    step(mkv(0, ri(LD,5,0,8'h00), 8'h61, 0, 0, 0, 8'h00, 1));
    step(mkv(0, rr(ALU,1,0,5), 8'h62, 0, 1, 0, 8'h00, 0));
    step(mkv(0, rr(ALU,1,0,5), 8'h62, 0, 0, 0, 8'h00, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ins_decode_ctrl_block.md
INS_DECODE_CTRL_BLOCK -- requirements
Module: ins_decode_ctrl_block

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, meaning the number of fetched instructions squashed after a taken redirect.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ins  input  20  instruction from the fetch block: opcode[19:15], rd[14:12], rs1[11:9], rs2[8:6], imm[7:0].
REQ-005 SHALL have port current_address  input  8  address of ins; registered alongside it as pc_d.
REQ-006 SHALL have port zero_flag  input  1  registered ALU zero result for the instruction ahead of the decode register.
REQ-007 SHALL have port jmp_loc  output  8  redirect target to fetch.
REQ-008 SHALL have port pc_mux_sel  output  1  1 = fetch takes jmp_loc.
REQ-009 SHALL have port stall  output  1  1 = fetch holds its address.
REQ-010 SHALL have port stall_pm  output  1  1 = fetch re-presents its held instruction.
REQ-011 SHALL have outputs opcode_d[4:0], rd_d[2:0], rs1_d[2:0], rs2_d[2:0], imm_d[7:0], pc_d[7:0], valid_d[1] to the execution block.

Function
REQ-012 SHALL decode opcodes: NOP=00000, LD=10000, ST=10001, JMP=11000, BEQZ=11001; every other code is ALU (uses rs1, rs2; writes rd).
REQ-013 SHALL implement FSM states RUN, STALL and FLUSH, plus a flush counter sized for FLUSH_DEPTH.
REQ-014 SHALL, in RUN with no hazard and no redirect, load ins fields into the decode register each cycle and set valid_d=1 (valid_d=0 if opcode is NOP).
REQ-015 SHALL detect a load-use hazard combinationally: valid_d=1, opcode_d=LD, and rd_d equal to a source register the incoming ins reads (rs1 for ALU/LD/ST/BEQZ, rs2 for ALU/ST).
REQ-016 SHALL, on hazard in RUN, assert stall=1 and stall_pm=1 that cycle, load a bubble (valid_d=0, opcode_d=NOP) at the edge, and enter STALL.
REQ-017 SHALL leave STALL for RUN after exactly one cycle, with stall=stall_pm=0 in STALL, so a load-use stall lasts one cycle.
REQ-018 SHALL assert a taken redirect when valid_d=1 and either opcode_d=JMP, or opcode_d=BEQZ with zero_flag=1.
REQ-019 SHALL, on a taken redirect, drive pc_mux_sel=1 and jmp_loc=imm_d for that single cycle; otherwise drive pc_mux_sel=0 and jmp_loc=0.
REQ-020 SHALL, on a taken redirect, load a bubble at the edge, enter FLUSH and load the counter with FLUSH_DEPTH-1.
REQ-021 SHALL, in FLUSH, load a bubble every cycle, decrement the counter, and return to RUN when the counter is 0; hazard detection and redirects are suppressed.
REQ-022 SHALL give a redirect priority over a simultaneous hazard: no stall, and FLUSH is entered.
REQ-023 SHALL never assert stall and pc_mux_sel in the same cycle.
REQ-024 SHALL treat FLUSH_DEPTH=1 as a single squashed instruction, with FLUSH exited after one cycle.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, set the state to RUN, the counter to 0, and all decode-register outputs to 0 (valid_d=0).
REQ-026 SHALL hold jmp_loc=0, pc_mux_sel=0, stall=0 and stall_pm=0 while reset=1.
REQ-027 SHALL let reset abort STALL or FLUSH mid-operation; the first cycle after release is RUN with no pending squash.

Structure
REQ-028 SHALL place the opcode constants, field bit positions, state encoding and the FLUSH_DEPTH default in shared package mips8_pkg.
REQ-029 SHALL keep hazard detection in one sub-module, hazard_detect (combinational: decode-register fields + ins -> hazard).

Verification
REQ-030 SHALL cover load-use: decode LD rd=3 with next ins ALU rs1=3 -> stall=stall_pm=1 for 1 cycle, then one bubble, then the ALU is decoded with valid_d=1.
REQ-031 SHALL cover no hazard: LD rd=3 followed by ALU rs1=2, rs2=4 -> stall stays 0 and there are no bubbles.
REQ-032 SHALL cover jump: JMP imm=0x40 in decode -> pc_mux_sel=1 and jmp_loc=0x40 for 1 cycle, then the next 2 ins are squashed (valid_d=0), and the third is decoded.
REQ-033 SHALL cover BEQZ both ways: BEQZ imm=0x10 with zero_flag=0 -> no redirect; with zero_flag=1 -> jmp_loc=0x10 and flush 2.
REQ-034 SHALL cover simultaneous events: JMP in decode while the incoming ins would hazard -> redirect only, stall=0.
REQ-035 SHALL cover reset mid-FLUSH: reset=1 for 1 cycle after a redirect -> all outputs 0, state RUN, and the next ins decoded normally.
